// File: rtl/count_down_timer_if.sv
// Control/status bundle for count_down_timer: strobes and mode in, counter and state flags out.
interface count_down_timer_if #(
    parameter int WIDTH = 4
);
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             stop;
    logic             periodic;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             paused;
    logic             done;
    logic             expire;

    // Controller side: issues commands, observes the timer
    modport master (
        output clear, load, load_val, start, stop, periodic,
        input  count, busy, paused, done, expire
    );

    // Timer side: accepts commands, reports its state
    modport slave (
        input  clear, load, load_val, start, stop, periodic,
        output count, busy, paused, done, expire
    );
endinterface

// File: rtl/count_down_timer.sv
// Loadable down-counter timer with one-shot/periodic modes, pause/resume and a fixed prescaler.
// Command priority each cycle: clear > load > stop > start.
module count_down_timer #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    count_down_timer_if.slave   bus
);
    // A single-cycle prescaler still needs a 1-bit register; it simply stays at 0.
    localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] count_r, count_nxt;
    logic [WIDTH-1:0] reload, reload_nxt;
    logic [PW-1:0]    pre, pre_nxt;
    logic             expire_nxt;
    logic             busy_r, paused_r, done_r, expire_r;
    logic             tick;

    assign tick = (pre == PRE_LAST);

    // Next-state and datapath decision for the coming edge
    always_comb begin
        state_nxt  = state;
        count_nxt  = count_r;
        reload_nxt = reload;
        pre_nxt    = pre;
        expire_nxt = 1'b0;
        if (bus.clear) begin
            state_nxt = IDLE;
            count_nxt = '0;
            pre_nxt   = '0;
        end else if (bus.load) begin
            count_nxt  = bus.load_val;
            reload_nxt = bus.load_val;
            case (state)
                RUN: begin
                    pre_nxt = '0;
                    if (bus.load_val == '0) state_nxt = IDLE;
                end
                PAUSE: begin
                    // Prescaler phase is kept so a later resume continues where it paused.
                    if (bus.load_val == '0) state_nxt = IDLE;
                end
                DONE:    state_nxt = IDLE;
                default: ;
            endcase
        end else if (bus.stop) begin
            if (state == RUN) state_nxt = PAUSE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && count_r != '0) begin
                        state_nxt = RUN;
                        pre_nxt   = '0;
                    end
                end
                PAUSE: begin
                    if (bus.start) state_nxt = RUN;
                end
                DONE: begin
                    if (bus.start && reload != '0) begin
                        state_nxt = RUN;
                        count_nxt = reload;
                        pre_nxt   = '0;
                    end
                end
                RUN: begin
                    pre_nxt = tick ? '0 : pre + PW'(1);
                    if (tick) begin
                        if (count_r > WIDTH'(1)) begin
                            count_nxt = count_r - WIDTH'(1);
                        end else if (count_r == WIDTH'(1)) begin
                            expire_nxt = 1'b1;
                            if (bus.periodic) begin
                                // Auto-reload skips the zero value entirely.
                                count_nxt = reload;
                            end else begin
                                count_nxt = '0;
                                state_nxt = DONE;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State, counter and registered status flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            count_r  <= '0;
            reload   <= '0;
            pre      <= '0;
            busy_r   <= 1'b0;
            paused_r <= 1'b0;
            done_r   <= 1'b0;
            expire_r <= 1'b0;
        end else begin
            state    <= state_nxt;
            count_r  <= count_nxt;
            reload   <= reload_nxt;
            pre      <= pre_nxt;
            busy_r   <= (state_nxt == RUN);
            paused_r <= (state_nxt == PAUSE);
            done_r   <= (state_nxt == DONE);
            expire_r <= expire_nxt;
        end
    end

    assign bus.count  = count_r;
    assign bus.busy   = busy_r;
    assign bus.paused = paused_r;
    assign bus.done   = done_r;
    assign bus.expire = expire_r;
endmodule

// File: tb/tb_count_down_timer.sv
// Bench for count_down_timer: a PRESCALE=1 and a PRESCALE=4 instance share one stimulus stream
// and are compared every cycle against a behavioural model of the timer rules.
module tb_count_down_timer;
    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_DONE  = 3;

    typedef struct packed {
        int st;
        int cnt;
        int rel;
        int runc;   // cycles spent running since the prescaler phase was last restarted
        bit exp;
    } mdl_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0, periodic = 1'b0;
    logic [3:0] load_val = '0;

    int   n_chk = 0;
    int   n_fail = 0;
    mdl_t m1, m4;

    count_down_timer_if #(.WIDTH(4)) bus1 ();
    count_down_timer_if #(.WIDTH(4)) bus4 ();

    assign bus1.clear = clear;  assign bus4.clear = clear;
    assign bus1.load = load;    assign bus4.load = load;
    assign bus1.load_val = load_val; assign bus4.load_val = load_val;
    assign bus1.start = start;  assign bus4.start = start;
    assign bus1.stop = stop;    assign bus4.stop = stop;
    assign bus1.periodic = periodic; assign bus4.periodic = periodic;

    count_down_timer #(.WIDTH(4), .PRESCALE(1)) dut1 (.clk(clk), .reset_n(rst_n), .bus(bus1));
    count_down_timer #(.WIDTH(4), .PRESCALE(4)) dut4 (.clk(clk), .reset_n(rst_n), .bus(bus4));

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m = '0;
        m.st = S_IDLE;
        return m;
    endfunction

    // One clock edge of the timer, written directly from the behavioural rules.
    function automatic mdl_t mdl_step(mdl_t m, int ps, bit c, bit l, int lv, bit s, bit sp, bit per);
        mdl_t n;
        n = m;
        n.exp = 1'b0;
        if (c) begin
            n.st = S_IDLE; n.cnt = 0; n.runc = 0;
        end else if (l) begin
            n.cnt = lv; n.rel = lv;
            if (m.st == S_RUN) n.runc = 0;
            if (lv == 0 || m.st == S_DONE) n.st = S_IDLE;
        end else if (sp) begin
            if (m.st == S_RUN) n.st = S_PAUSE;
        end else if (m.st == S_RUN) begin
            n.runc = m.runc + 1;
            if (n.runc % ps == 0) begin
                if (m.cnt > 1) n.cnt = m.cnt - 1;
                else if (m.cnt == 1) begin
                    n.exp = 1'b1;
                    if (per) n.cnt = m.rel;
                    else begin n.cnt = 0; n.st = S_DONE; end
                end
            end
        end else if (s) begin
            if (m.st == S_IDLE && m.cnt != 0) begin n.st = S_RUN; n.runc = 0; end
            else if (m.st == S_PAUSE) n.st = S_RUN;
            else if (m.st == S_DONE && m.rel != 0) begin n.st = S_RUN; n.cnt = m.rel; n.runc = 0; end
        end
        return n;
    endfunction

    task automatic compare_all();
        check_val("p1_count",  int'(bus1.count),  m1.cnt);
        check_val("p1_busy",   int'(bus1.busy),   int'(m1.st == S_RUN));
        check_val("p1_paused", int'(bus1.paused), int'(m1.st == S_PAUSE));
        check_val("p1_done",   int'(bus1.done),   int'(m1.st == S_DONE));
        check_val("p1_expire", int'(bus1.expire), int'(m1.exp));
        check_val("p4_count",  int'(bus4.count),  m4.cnt);
        check_val("p4_busy",   int'(bus4.busy),   int'(m4.st == S_RUN));
        check_val("p4_paused", int'(bus4.paused), int'(m4.st == S_PAUSE));
        check_val("p4_done",   int'(bus4.done),   int'(m4.st == S_DONE));
        check_val("p4_expire", int'(bus4.expire), int'(m4.exp));
    endtask

    // Apply one cycle of commands, advance the model on the edge, then check just after it.
    task automatic cyc(input bit c, input bit l, input int lv, input bit s, input bit sp);
        clear = c; load = l; load_val = lv[3:0]; start = s; stop = sp;
        @(posedge clk);
        if (!rst_n) begin
            m1 = mdl_reset(); m4 = mdl_reset();
        end else begin
            m1 = mdl_step(m1, 1, c, l, lv, s, sp, periodic);
            m4 = mdl_step(m4, 4, c, l, lv, s, sp, periodic);
        end
        #1;
        compare_all();
        clear = 0; load = 0; start = 0; stop = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    initial begin
        m1 = mdl_reset();
        m4 = mdl_reset();
        // Reset state
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // One-shot countdown from 5
        periodic = 0;
        cyc(0, 1, 5, 0, 0);
        cyc(0, 0, 0, 1, 0);
        idle(8);
        check_val("oneshot_done", int'(bus1.done), 1);
        cyc(1, 0, 0, 0, 0);
        idle(14);

        // Periodic reload of 3
        periodic = 1;
        cyc(0, 1, 3, 0, 0);
        cyc(0, 0, 0, 1, 0);
        idle(14);
        check_val("periodic_done", int'(bus1.done), 0);
        cyc(1, 0, 0, 0, 0);
        periodic = 0;

        // Pause at 5 for ten cycles, then resume
        cyc(0, 1, 8, 0, 0);
        cyc(0, 0, 0, 1, 0);
        idle(3);
        check_val("pause_at", int'(bus1.count), 5);
        cyc(0, 0, 0, 0, 1);
        idle(10);
        cyc(0, 0, 0, 1, 0);
        idle(4);
        cyc(1, 0, 0, 0, 0);

        // Priority and load-zero abort
        cyc(1, 1, 9, 1, 0);
        cyc(0, 1, 6, 0, 0);
        cyc(0, 0, 0, 1, 0);
        idle(2);
        cyc(0, 1, 0, 0, 0);
        idle(8);
        cyc(0, 1, 7, 1, 1);
        cyc(0, 0, 0, 1, 1);
        idle(2);
        cyc(1, 0, 0, 0, 0);

        // Prescaled expiry from 2
        cyc(0, 1, 2, 0, 0);
        cyc(0, 0, 0, 1, 0);
        idle(10);
        cyc(1, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a count
        cyc(0, 1, 9, 0, 0);
        cyc(0, 0, 0, 1, 0);
        idle(2);
        check_val("pre_reset_count", int'(bus1.count), 7);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_count", int'(bus1.count), 0);
        check_val("async_busy",  int'(bus1.busy), 0);
        check_val("async_p4",    int'(bus4.count), 0);
        m1 = mdl_reset(); m4 = mdl_reset();
        idle(2);
        #2;
        rst_n = 1'b1;
        cyc(0, 0, 0, 1, 0);
        idle(3);

        // Randomised command stream
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) periodic = ~periodic;
            cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 11) == 0),
                int'($urandom_range(0, 15)), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 14) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
